linear_ccd_sequencer: RTL and testbench

Parametrised sequencer for linear CCD sensors with a pipelined ADC. It generates the reset, integration and readout waveforms, strobes the ADC, and delivers one sample per pixel to the downstream frame buffer write port. It succeeds the fixed 1024-pixel single-shot controller. New capabilities: configurable pixel count, ADC width and timing, runtime integration time and resolution mode, continuous free-running frames, and FIFO back-pressure detection.

---
 rtl/linear_ccd_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_linear_ccd_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_ccd_sequencer.sv
// Linear CCD timing sequencer: reset/integration/readout waveforms, ADC strobing
// and per-pixel sample delivery to a frame buffer write port.
module linear_ccd_sequencer #(
    parameter int PIXELS    = 1024,
    parameter int ADC_W     = 8,
    parameter int HALF_PER  = 50,
    parameter int RESET_CYC = 1000,
    parameter int ADC_DLY   = 20,
    parameter int INT_W     = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [INT_W-1:0]          int_time,
    input  logic [1:0]                res_mode,
    input  logic [ADC_W-1:0]          ad_data,
    input  logic                      fifo_full,
    output logic                      ad_clk,
    output logic                      ad_oe,
    output logic                      ccd_clk,
    output logic                      ccd_rst,
    output logic                      ccd_sht,
    output logic                      ccd_data,
    output logic                      ccd_m0,
    output logic                      ccd_m1,
    output logic                      ccd_rm,
    output logic [ADC_W-1:0]          pix_data,
    output logic                      pix_valid,
    output logic                      pix_last,
    output logic [$clog2(PIXELS)-1:0] pix_idx,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overflow,
    output logic [15:0]               frame_cnt
);
    localparam int IW = $clog2(PIXELS);
    localparam int HW = $clog2(HALF_PER);
    localparam int RW = $clog2(RESET_CYC + 1);
    localparam int CW = (INT_W > RW) ? INT_W : RW;

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_INTEG, S_START, S_READOUT, S_DONE} state_t;

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [HW-1:0]      hcnt_r, hcnt_s;
    logic [1:0]         sub_r, sub_s;
    logic [IW-1:0]      idx_r, idx_s;
    logic [INT_W-1:0]   int_r, int_s;
    logic [1:0]         mode_r, mode_s;
    logic               ovf_r, ovf_s;
    logic [15:0]        fcnt_r, fcnt_s;
    logic               new_frame_s, hwrap_s, pend_r, cap_s, active_s;
    logic               ad_clk_r, ad_clk_s, ad_oe_r, ad_oe_s, ccd_clk_r, ccd_clk_s;
    logic               ccd_rst_r, ccd_rst_s, ccd_sht_r, ccd_sht_s, ccd_data_r, ccd_data_s;
    logic [1:0]         ccd_m_r, ccd_m_s;
    logic [ADC_W-1:0]   pix_data_r, pix_data_s;
    logic               pix_valid_r, pix_valid_s, pix_last_r, pix_last_s;
    logic               busy_r, busy_s, done_r, done_s;

    // Next-state and counter sequencing.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        hcnt_s      = hcnt_r;
        sub_s       = sub_r;
        idx_s       = idx_r;
        fcnt_s      = fcnt_r;
        new_frame_s = 1'b0;
        hwrap_s     = (hcnt_r == HW'(HALF_PER - 1));
        case (state_r)
            S_IDLE: begin
                if (start || continuous) begin
                    state_s     = S_RESET;
                    cnt_s       = {CW{1'b0}};
                    new_frame_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RESET: begin
                if (cnt_r == CW'(RESET_CYC - 1)) begin
                    state_s = S_INTEG;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            S_INTEG: begin
                if (cnt_r == CW'(int_r) - CW'(1)) begin
                    state_s = S_START;
                    cnt_s   = {CW{1'b0}};
                    hcnt_s  = {HW{1'b0}};
                    sub_s   = 2'd0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            S_START: begin
                if (hwrap_s) begin
                    hcnt_s = {HW{1'b0}};
                    if (sub_r == 2'd3) begin
                        state_s = S_READOUT;
                        sub_s   = 2'd0;
                        idx_s   = {IW{1'b0}};
                    end else begin
                        sub_s = sub_r + 2'd1;
                    end
                end else begin
                    hcnt_s = hcnt_r + HW'(1);
                end
            end
            S_READOUT: begin
                if (hwrap_s) begin
                    hcnt_s = {HW{1'b0}};
                    if (sub_r[0]) begin
                        sub_s = 2'd0;
                        if (idx_r == IW'(PIXELS - 1)) begin
                            state_s = S_DONE;
                            idx_s   = {IW{1'b0}};
                            fcnt_s  = fcnt_r + 16'd1;
                        end else begin
                            idx_s = idx_r + IW'(1);
                        end
                    end else begin
                        sub_s = 2'd1;
                    end
                end else begin
                    hcnt_s = hcnt_r + HW'(1);
                end
            end
            S_DONE: begin
                if (continuous) begin
                    state_s     = S_RESET;
                    cnt_s       = {CW{1'b0}};
                    new_frame_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Per-frame settings latch and sticky drop flag.
    always_comb begin
        int_s  = int_r;
        mode_s = mode_r;
        if (pend_r && fifo_full) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = ovf_r;
        end
        if (new_frame_s) begin
            int_s  = (int_time == {INT_W{1'b0}}) ? INT_W'(1) : int_time;
            mode_s = res_mode;
            ovf_s  = 1'b0;
        end else begin
            int_s  = int_r;
            mode_s = mode_r;
        end
    end

    // Output decode from the upcoming state so every pin is a flop aligned with its state.
    always_comb begin
        active_s    = (state_s == S_RESET) || (state_s == S_INTEG) ||
                      (state_s == S_START) || (state_s == S_READOUT);
        ad_clk_s    = (state_s == S_READOUT) &&
                      (sub_s[0] ? (hcnt_s < HW'(ADC_DLY)) : (hcnt_s >= HW'(ADC_DLY)));
        cap_s       = ad_clk_r && !ad_clk_s;
        ad_oe_s     = (state_s == S_RESET);
        ccd_rst_s   = (state_s == S_RESET);
        ccd_sht_s   = (state_s == S_RESET) || (state_s == S_INTEG);
        ccd_clk_s   = (state_s == S_RESET) ||
                      ((state_s == S_START) && ((sub_s == 2'd0) || (sub_s == 2'd3))) ||
                      ((state_s == S_READOUT) && !sub_s[0]);
        ccd_data_s  = (state_s == S_START) && sub_s[1];
        ccd_m_s     = active_s ? mode_s : 2'b00;
        busy_s      = (state_s != S_IDLE);
        done_s      = (state_s == S_DONE);
        pix_valid_s = pend_r && !fifo_full;
        pix_last_s  = pend_r && !fifo_full && (idx_r == IW'(PIXELS - 1));
        if (state_s == S_DONE) begin
            pix_data_s = {ADC_W{1'b0}};
        end else if (cap_s) begin
            pix_data_s = ad_data;
        end else begin
            pix_data_s = pix_data_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            hcnt_r      <= {HW{1'b0}};
            sub_r       <= 2'd0;
            idx_r       <= {IW{1'b0}};
            int_r       <= {INT_W{1'b0}};
            mode_r      <= 2'd0;
            ovf_r       <= 1'b0;
            fcnt_r      <= 16'd0;
            pend_r      <= 1'b0;
            ad_clk_r    <= 1'b0;
            ad_oe_r     <= 1'b0;
            ccd_clk_r   <= 1'b0;
            ccd_rst_r   <= 1'b0;
            ccd_sht_r   <= 1'b0;
            ccd_data_r  <= 1'b0;
            ccd_m_r     <= 2'd0;
            pix_data_r  <= {ADC_W{1'b0}};
            pix_valid_r <= 1'b0;
            pix_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hcnt_r      <= hcnt_s;
            sub_r       <= sub_s;
            idx_r       <= idx_s;
            int_r       <= int_s;
            mode_r      <= mode_s;
            ovf_r       <= ovf_s;
            fcnt_r      <= fcnt_s;
            pend_r      <= cap_s;
            ad_clk_r    <= ad_clk_s;
            ad_oe_r     <= ad_oe_s;
            ccd_clk_r   <= ccd_clk_s;
            ccd_rst_r   <= ccd_rst_s;
            ccd_sht_r   <= ccd_sht_s;
            ccd_data_r  <= ccd_data_s;
            ccd_m_r     <= ccd_m_s;
            pix_data_r  <= pix_data_s;
            pix_valid_r <= pix_valid_s;
            pix_last_r  <= pix_last_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign ad_clk     = ad_clk_r;
    assign ad_oe      = ad_oe_r;
    assign ccd_clk    = ccd_clk_r;
    assign ccd_rst    = ccd_rst_r;
    assign ccd_sht    = ccd_sht_r;
    assign ccd_data   = ccd_data_r;
    assign ccd_m0     = ccd_m_r[0];
    assign ccd_m1     = ccd_m_r[1];
    assign ccd_rm     = 1'b0;
    assign pix_data   = pix_data_r;
    assign pix_valid  = pix_valid_r;
    assign pix_last   = pix_last_r;
    assign pix_idx    = idx_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign overflow   = ovf_r;
    assign frame_cnt  = fcnt_r;
endmodule

// File: tb/tb_linear_ccd_sequencer.sv
// Directed bench for linear_ccd_sequencer with PIXELS=8, HALF_PER=4, RESET_CYC=10, ADC_DLY=1.
module tb_linear_ccd_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, continuous, fifo_full, bp_en;
    logic [25:0] int_time;
    logic [1:0]  res_mode;
    logic [7:0]  ad_data;
    logic        ad_clk, ad_oe, ccd_clk, ccd_rst, ccd_sht, ccd_data, ccd_m0, ccd_m1, ccd_rm;
    logic [7:0]  pix_data;
    logic        pix_valid, pix_last, busy, frame_done, overflow;
    logic [2:0]  pix_idx;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int rstart_q[$];
    int done_q[$];
    int val_cyc_q[$];
    logic [7:0] val_dat_q[$];
    int obs_rst_last, obs_sht_fall, obs_busy_low, last_cnt, mode_bad;
    logic [7:0] last_dat;
    logic [1:0] exp_mode = 2'b00;
    int hook_int_cyc = -1;
    int hook_cont_off = -1;
    int hook_start = -1;
    logic [25:0] hook_int_val = 26'd0;

    linear_ccd_sequencer #(
        .PIXELS(8), .ADC_W(8), .HALF_PER(4), .RESET_CYC(10), .ADC_DLY(1), .INT_W(26)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .int_time(int_time), .res_mode(res_mode), .ad_data(ad_data), .fifo_full(fifo_full),
        .ad_clk(ad_clk), .ad_oe(ad_oe), .ccd_clk(ccd_clk), .ccd_rst(ccd_rst),
        .ccd_sht(ccd_sht), .ccd_data(ccd_data), .ccd_m0(ccd_m0), .ccd_m1(ccd_m1),
        .ccd_rm(ccd_rm), .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last),
        .pix_idx(pix_idx), .busy(busy), .frame_done(frame_done), .overflow(overflow),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // ADC returns 0x10 + pixel index; FIFO stalls over pixels 3 and 4 when enabled.
    assign ad_data   = {5'b00010, pix_idx};
    assign fifo_full = bp_en && ((pix_idx == 3'd3) || (pix_idx == 3'd4));

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Cycle c is the c-th negedge after the edge that samples the request.
    task automatic observe(input int n);
        logic p_rst, p_sht;
        rstart_q.delete(); done_q.delete(); val_cyc_q.delete(); val_dat_q.delete();
        obs_rst_last = -1; obs_sht_fall = -1; obs_busy_low = -1;
        last_cnt = 0; last_dat = 8'd0; mode_bad = 0;
        p_rst = ccd_rst;
        p_sht = ccd_sht;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == hook_int_cyc) int_time = hook_int_val;
            if (c == hook_cont_off) continuous = 1'b0;
            if (c == hook_start) start = 1'b1;
            if (c == hook_start + 1) start = 1'b0;
            if (ccd_rst && !p_rst) rstart_q.push_back(c);
            if (ccd_rst) obs_rst_last = c;
            if (!ccd_sht && p_sht && obs_sht_fall < 0) obs_sht_fall = c;
            if (frame_done) done_q.push_back(c);
            if (pix_valid) begin
                val_cyc_q.push_back(c);
                val_dat_q.push_back(pix_data);
                if (pix_last) begin
                    last_cnt++;
                    last_dat = pix_data;
                end
            end
            if (!busy && obs_busy_low < 0) obs_busy_low = c;
            if (busy && !frame_done && ({ccd_m1, ccd_m0} !== exp_mode)) mode_bad++;
            p_rst = ccd_rst;
            p_sht = ccd_sht;
        end
        hook_int_cyc = -1; hook_cont_off = -1; hook_start = -1;
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; bp_en = 1'b0;
        int_time = 26'd5; res_mode = 2'b00;
        repeat (3) @(negedge clk);
        outs = {ad_clk, ad_oe, ccd_clk, ccd_rst, ccd_sht, ccd_data, ccd_m0, ccd_m1, ccd_rm,
                pix_data, pix_valid, pix_last, pix_idx, busy, frame_done, overflow, frame_cnt};
        n_cmp++;
        if (outs !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_single_shot();
        int got;
        kick();
        observe(110);
        got = (rstart_q.size() > 0) ? rstart_q[0] : -1;
        n_cmp++;
        if (got !== 1 || rstart_q.size() !== 1) begin
            n_bad++;
            $display("FAIL single_rst_rise got %0d (n=%0d) want 1", got, rstart_q.size());
        end
        n_cmp++;
        if (obs_rst_last !== 10) begin
            n_bad++;
            $display("FAIL single_rst_last got %0d want 10", obs_rst_last);
        end
        n_cmp++;
        if (obs_sht_fall !== 16) begin
            n_bad++;
            $display("FAIL single_sht_fall got %0d want 16", obs_sht_fall);
        end
        got = (done_q.size() > 0) ? done_q[0] : -1;
        n_cmp++;
        if (got !== 96 || done_q.size() !== 1) begin
            n_bad++;
            $display("FAIL single_done got %0d (n=%0d) want 96", got, done_q.size());
        end
        n_cmp++;
        if (obs_busy_low !== 97) begin
            n_bad++;
            $display("FAIL single_busy_low got %0d want 97", obs_busy_low);
        end
        n_cmp++;
        if (frame_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL single_frame_cnt got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_data_path();
        kick();
        observe(110);
        n_cmp++;
        if (val_cyc_q.size() !== 8) begin
            n_bad++;
            $display("FAIL data_valid_count got %0d want 8", val_cyc_q.size());
        end
        for (int i = 0; i < val_cyc_q.size() && i < 8; i++) begin
            n_cmp++;
            if (val_dat_q[i] !== 8'h10 + 8'(i) || val_cyc_q[i] !== 38 + 8 * i) begin
                n_bad++;
                $display("FAIL data_pixel_%0d got %h@%0d want %h@%0d", i, val_dat_q[i],
                         val_cyc_q[i], 8'h10 + 8'(i), 38 + 8 * i);
            end
        end
        n_cmp++;
        if (last_cnt !== 1 || last_dat !== 8'h17) begin
            n_bad++;
            $display("FAIL data_last got %0d x %h want 1 x 17", last_cnt, last_dat);
        end
        n_cmp++;
        if (overflow !== 1'b0 || frame_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL data_ovf_cnt got %b/%0d want 0/2", overflow, frame_cnt);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] d3;
        bp_en = 1'b1;
        kick();
        observe(110);
        bp_en = 1'b0;
        n_cmp++;
        if (val_cyc_q.size() !== 6) begin
            n_bad++;
            $display("FAIL bp_valid_count got %0d want 6", val_cyc_q.size());
        end
        d3 = (val_dat_q.size() > 3) ? val_dat_q[3] : 8'h00;
        n_cmp++;
        if (d3 !== 8'h15) begin
            n_bad++;
            $display("FAIL bp_fourth_sample got %h want 15", d3);
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_overflow_set got %b want 1", overflow);
        end
        kick();
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_overflow_clear got %b busy %b want 0 busy 1", overflow, busy);
        end
        observe(110);
        n_cmp++;
        if (frame_cnt !== 16'd4 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_second_frame got %0d/%b want 4/0", frame_cnt, overflow);
        end
    endtask

    task automatic test_continuous();
        int d0, d1, d2, r0, r1, r2;
        int_time = 26'd5;
        @(negedge clk);
        continuous = 1'b1;
        hook_int_cyc = 50; hook_int_val = 26'd9; hook_cont_off = 210;
        observe(320);
        int_time = 26'd5;
        d0 = (done_q.size() > 0) ? done_q[0] : -1;
        d1 = (done_q.size() > 1) ? done_q[1] : -1;
        d2 = (done_q.size() > 2) ? done_q[2] : -1;
        n_cmp++;
        if (done_q.size() !== 3 || d0 !== 96 || d1 !== 196 || d2 !== 296) begin
            n_bad++;
            $display("FAIL cont_done got %0d,%0d,%0d (n=%0d) want 96,196,296",
                     d0, d1, d2, done_q.size());
        end
        r0 = (rstart_q.size() > 0) ? rstart_q[0] : -1;
        r1 = (rstart_q.size() > 1) ? rstart_q[1] : -1;
        r2 = (rstart_q.size() > 2) ? rstart_q[2] : -1;
        n_cmp++;
        if (rstart_q.size() !== 3 || r0 !== 1 || r1 !== 97 || r2 !== 197) begin
            n_bad++;
            $display("FAIL cont_reset_start got %0d,%0d,%0d (n=%0d) want 1,97,197",
                     r0, r1, r2, rstart_q.size());
        end
        n_cmp++;
        if (obs_busy_low !== 297 || frame_cnt !== 16'd7) begin
            n_bad++;
            $display("FAIL cont_end got idle@%0d cnt %0d want idle@297 cnt 7",
                     obs_busy_low, frame_cnt);
        end
    endtask

    task automatic test_robustness();
        int got;
        logic [40:0] outs;
        logic stayed_idle;
        kick();
        hook_start = 40;
        observe(110);
        got = (done_q.size() > 0) ? done_q[0] : -1;
        n_cmp++;
        if (done_q.size() !== 1 || got !== 96 || rstart_q.size() !== 1 || obs_busy_low !== 97) begin
            n_bad++;
            $display("FAIL rob_start_ignored got done %0d (n=%0d) resets %0d idle@%0d want 96/1/1/97",
                     got, done_q.size(), rstart_q.size(), obs_busy_low);
        end
        kick();
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        outs = {ad_clk, ad_oe, ccd_clk, ccd_rst, ccd_sht, ccd_data, ccd_m0, ccd_m1, ccd_rm,
                pix_data, pix_valid, pix_last, pix_idx, busy, frame_done, overflow, frame_cnt};
        n_cmp++;
        if (outs !== 41'd0) begin
            n_bad++;
            $display("FAIL rob_midframe_reset got %h want 0", outs);
        end
        rst = 1'b0;
        stayed_idle = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy || ccd_rst || ccd_sht) stayed_idle = 1'b0;
        end
        n_cmp++;
        if (stayed_idle !== 1'b1) begin
            n_bad++;
            $display("FAIL rob_idle_after_reset got %b want 1", stayed_idle);
        end
    endtask

    task automatic test_edge_cases();
        int got;
        int_time = 26'd0;
        res_mode = 2'b10;
        exp_mode = 2'b10;
        kick();
        observe(110);
        exp_mode = 2'b00;
        int_time = 26'd5;
        res_mode = 2'b00;
        n_cmp++;
        if (obs_sht_fall !== 12) begin
            n_bad++;
            $display("FAIL edge_int_zero got sht_fall %0d want 12", obs_sht_fall);
        end
        got = (done_q.size() > 0) ? done_q[0] : -1;
        n_cmp++;
        if (got !== 92) begin
            n_bad++;
            $display("FAIL edge_done got %0d want 92", got);
        end
        n_cmp++;
        if (mode_bad !== 0) begin
            n_bad++;
            $display("FAIL edge_mode_pins got %0d bad cycles want 0", mode_bad);
        end
        n_cmp++;
        if (frame_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL edge_frame_cnt got %0d want 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_data_path();
        test_back_pressure();
        test_continuous();
        test_robustness();
        test_edge_cases();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
